// File: rtl/alu_share_arb.sv
// Arbitrates two requesters onto one combinational ALU through a registered operand stage
// and a held response register per port. Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module alu_share_arb #(
  parameter int W   = 32,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic [31:0]    req0_ir,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [OPW-1:0] req1_op,
  input  logic [31:0]    req1_ir,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [W-1:0]   rsp0_c,
  output logic           rsp0_zero,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [W-1:0]   rsp1_c,
  output logic           rsp1_zero,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  output logic [31:0]    alu_ir,
  input  logic [W-1:0]   alu_c,
  input  logic           alu_zero
);

  // Handshake: a request transfers on an edge where valid & ready are both high; a response
  // transfers on an edge where rspi_valid & rspi_ready are both high. Held data is stable otherwise.
  logic [1:0] inflight;   // one-hot owner of the operand register, doubles as the tag
  logic [1:0] rsp_valid;
  logic [1:0] busy;
  logic       elig0, elig1;
  logic       grant0, grant1;

  assign busy  = inflight | rsp_valid;
  assign elig0 = req0_valid & ~busy[0] & reset_n;
  assign elig1 = req1_valid & ~busy[1] & reset_n;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant0 = elig0;
  assign grant1 = elig1 & ~elig0;
`else
  logic rr;

  assign grant0 = elig0 & (~elig1 | ~rr);
  assign grant1 = elig1 & (~elig0 | rr);

  // The pointer moves away from a port only when that port wins while preferred.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr <= 1'b0;
    end else if (!rr && grant0) begin
      rr <= 1'b1;
    end else if (rr && grant1) begin
      rr <= 1'b0;
    end
  end
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      alu_ir <= '0;
    end else if (grant0) begin
      alu_a  <= req0_a;
      alu_b  <= req0_b;
      alu_op <= req0_op;
      alu_ir <= req0_ir;
    end else if (grant1) begin
      alu_a  <= req1_a;
      alu_b  <= req1_b;
      alu_op <= req1_op;
      alu_ir <= req1_ir;
    end
  end

  // The ALU is single-cycle, so whatever was accepted last edge is captured this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 2'b00;
    end else begin
      inflight <= {grant1, grant0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid[0] <= 1'b0;
      rsp0_c       <= '0;
      rsp0_zero    <= 1'b0;
    end else if (inflight[0]) begin
      rsp_valid[0] <= 1'b1;
      rsp0_c       <= alu_c;
      rsp0_zero    <= alu_zero;
    end else if (rsp_valid[0] && rsp0_ready) begin
      rsp_valid[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid[1] <= 1'b0;
      rsp1_c       <= '0;
      rsp1_zero    <= 1'b0;
    end else if (inflight[1]) begin
      rsp_valid[1] <= 1'b1;
      rsp1_c       <= alu_c;
      rsp1_zero    <= alu_zero;
    end else if (rsp_valid[1] && rsp1_ready) begin
      rsp_valid[1] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a behavioural ALU, directed scenario tasks and a per-port
// expected-result queue filled on accept and drained on response hand-off.
module tb_alu_share_arb;
  localparam int W   = 32;
  localparam int OPW = 4;

  logic           clk;
  logic           reset_n;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0] req0_op, req1_op;
  logic [31:0]    req0_ir, req1_ir;
  logic           rsp0_valid, rsp1_valid;
  logic           rsp0_ready, rsp1_ready;
  logic [W-1:0]   rsp0_c, rsp1_c;
  logic           rsp0_zero, rsp1_zero;
  logic [W-1:0]   alu_a, alu_b;
  logic [OPW-1:0] alu_op;
  logic [31:0]    alu_ir;
  logic [W-1:0]   alu_c;
  logic           alu_zero;

  int vectors    = 0;
  int miscompares = 0;
  logic [W:0] exp_q0[$];
  logic [W:0] exp_q1[$];

  // ALU: 1=ADD, 2=SUB, 3=SRA of b by shamt; zero flags a==b. Returns {zero, c}.
  function automatic logic [W:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [OPW-1:0] op, input logic [4:0] sh);
    logic signed [W-1:0] sb;
    logic [W-1:0] c;
    sb = b;
    case (op)
      4'd1:    c = a + b;
      4'd2:    c = a - b;
      4'd3:    c = sb >>> sh;
      default: c = '0;
    endcase
    return {(a == b), c};
  endfunction

  logic [W:0] alu_res;
  assign alu_res  = alu_model(alu_a, alu_b, alu_op, alu_ir[10:6]);
  assign alu_c    = alu_res[W-1:0];
  assign alu_zero = alu_res[W];

  alu_share_arb #(.W(W), .OPW(OPW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_ir(req0_ir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_ir(req1_ir),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ir(alu_ir),
    .alu_c(alu_c), .alu_zero(alu_zero)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: push on accept, pop and compare on response hand-off.
  always @(negedge clk) begin
    logic [W:0] exp_v;
    if (req0_valid && req0_ready) exp_q0.push_back(alu_model(req0_a, req0_b, req0_op, req0_ir[10:6]));
    if (req1_valid && req1_ready) exp_q1.push_back(alu_model(req1_a, req1_b, req1_op, req1_ir[10:6]));
    if (rsp0_valid && rsp0_ready) begin
      vectors++;
      if (exp_q0.size() == 0) begin
        miscompares++;
        $display("FAIL sb_rsp0: unexpected response c=%h zero=%b", rsp0_c, rsp0_zero);
      end else begin
        exp_v = exp_q0.pop_front();
        if ({rsp0_zero, rsp0_c} !== exp_v) begin
          miscompares++;
          $display("FAIL sb_rsp0: got %h expected %h", {rsp0_zero, rsp0_c}, exp_v);
        end
      end
    end
    if (rsp1_valid && rsp1_ready) begin
      vectors++;
      if (exp_q1.size() == 0) begin
        miscompares++;
        $display("FAIL sb_rsp1: unexpected response c=%h zero=%b", rsp1_c, rsp1_zero);
      end else begin
        exp_v = exp_q1.pop_front();
        if ({rsp1_zero, rsp1_c} !== exp_v) begin
          miscompares++;
          $display("FAIL sb_rsp1: got %h expected %h", {rsp1_zero, rsp1_c}, exp_v);
        end
      end
    end
  end

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [OPW-1:0] op, input logic [31:0] ir);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_ir = ir;
  endtask

  task automatic drive1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [OPW-1:0] op, input logic [31:0] ir);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_ir = ir;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive0(1'b1, 32'h1, 32'h2, 4'd1, 32'h0);
    drive1(1'b1, 32'h3, 32'h4, 4'd2, 32'h0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready});
    end
    vectors++;
    if ({rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero} !== 4'b0000 || rsp0_c !== '0 || rsp1_c !== '0) begin
      miscompares++; $display("FAIL reset_rsp: valid=%b%b c0=%h c1=%h required all 0", rsp0_valid, rsp1_valid, rsp0_c, rsp1_c);
    end
    vectors++;
    if (alu_a !== '0 || alu_b !== '0 || alu_op !== '0 || alu_ir !== '0) begin
      miscompares++; $display("FAIL reset_alu: a=%h b=%h op=%h ir=%h required 0", alu_a, alu_b, alu_op, alu_ir);
    end
    drive0(1'b0, '0, '0, '0, '0);
    drive1(1'b0, '0, '0, '0, '0);
    step();
    reset_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single();
    step();
    drive0(1'b1, 32'd5, 32'd3, 4'd1, 32'h0);
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++; $display("FAIL single_ready: got %b required 1", req0_ready);
    end
    step();
    drive0(1'b0, 32'd0, 32'd0, 4'd0, 32'h0);
    @(negedge clk);
    vectors++;
    if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 4'd1 || rsp0_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_operands: a=%h b=%h op=%h rsp_valid=%b required 5 3 1 0", alu_a, alu_b, alu_op, rsp0_valid);
    end
    step();
    @(negedge clk);
    vectors++;
    if (rsp0_valid !== 1'b1 || rsp0_c !== 32'd8 || rsp0_zero !== 1'b0) begin
      miscompares++; $display("FAIL single_result: valid=%b c=%h zero=%b required 1 8 0", rsp0_valid, rsp0_c, rsp0_zero);
    end
    repeat (3) step();
  endtask

  task automatic test_contention();
    int last = -1;
    int ng = 0;
    int g;
    int first_exp;
`ifdef ALU_ARB_FIXED_PRIO_EN
    first_exp = 0;
`else
    first_exp = 1;  // the earlier port-0 accept left the pointer preferring port 1
`endif
    drive0(1'b1, 32'd1, 32'd1, 4'd1, 32'h0);
    drive1(1'b1, 32'd7, 32'd7, 4'd2, 32'h0);
    repeat (12) begin
      @(negedge clk);
      if (req0_ready && req1_ready) begin
        vectors++; miscompares++; $display("FAIL contention_double: both ports granted");
      end
      g = req0_ready ? 0 : (req1_ready ? 1 : -1);
      if (g >= 0) begin
        vectors++;
        if (last < 0 && g != first_exp) begin
          miscompares++; $display("FAIL contention_first: got port %0d required port %0d", g, first_exp);
        end else if (last >= 0 && g == last) begin
          miscompares++; $display("FAIL contention_alternate: port %0d granted twice in a row", g);
        end
        last = g;
        ng++;
      end
      if (rsp1_valid) begin
        vectors++;
        if (rsp1_c !== 32'd0 || rsp1_zero !== 1'b1) begin
          miscompares++; $display("FAIL contention_sub: c=%h zero=%b required 0 1", rsp1_c, rsp1_zero);
        end
      end
    end
    vectors++;
    if (ng != 8) begin
      miscompares++; $display("FAIL contention_count: got %0d grants required 8", ng);
    end
    step();
    drive0(1'b0, '0, '0, '0, '0);
    drive1(1'b0, '0, '0, '0, '0);
    repeat (3) step();
  endtask

  task automatic test_backpressure();
    logic [31:0] ir;
    ir = 32'h0;
    ir[10:6] = 5'd4;
    ir[31] = 1'b1;
    rsp1_ready = 1'b0;
    drive1(1'b1, 32'h0, 32'h8000_0000, 4'd3, ir);
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_accept: got %b required 1", req1_ready);
    end
    step();
    @(negedge clk);
    vectors++;
    if (alu_ir !== ir || req1_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_ir: alu_ir=%h ready=%b required %h 0", alu_ir, req1_ready, ir);
    end
    repeat (5) begin
      step();
      @(negedge clk);
      vectors++;
      if (rsp1_valid !== 1'b1 || rsp1_c !== 32'hF800_0000 || rsp1_zero !== 1'b0 || req1_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold: valid=%b c=%h zero=%b ready=%b required 1 f8000000 0 0", rsp1_valid, rsp1_c, rsp1_zero, req1_ready);
      end
    end
    step();
    rsp1_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_drain_edge: ready=%b required 0", req1_ready);
    end
    step();
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b1 || rsp1_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_reaccept: ready=%b rsp_valid=%b required 1 0", req1_ready, rsp1_valid);
    end
    step();
    drive1(1'b0, '0, '0, '0, '0);
    repeat (3) step();
  endtask

  task automatic test_overlap();
    drive0(1'b1, 32'd10, 32'd20, 4'd1, 32'h0);
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++; $display("FAIL ovl_accept0: got %b required 1", req0_ready);
    end
    step();
    drive0(1'b0, '0, '0, '0, '0);
    drive1(1'b1, 32'd100, 32'd1, 4'd2, 32'h0);
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
      miscompares++; $display("FAIL ovl_accept1: ready1=%b rsp0_valid=%b required 1 0", req1_ready, rsp0_valid);
    end
    step();
    drive1(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    vectors++;
    if (rsp0_valid !== 1'b1 || rsp0_c !== 32'd30 || rsp1_valid !== 1'b0) begin
      miscompares++; $display("FAIL ovl_rsp0: valid0=%b c0=%h valid1=%b required 1 1e 0", rsp0_valid, rsp0_c, rsp1_valid);
    end
    step();
    @(negedge clk);
    vectors++;
    if (rsp1_valid !== 1'b1 || rsp1_c !== 32'd99 || rsp1_zero !== 1'b0 || rsp0_valid !== 1'b0) begin
      miscompares++; $display("FAIL ovl_rsp1: valid1=%b c1=%h zero1=%b valid0=%b required 1 63 0 0", rsp1_valid, rsp1_c, rsp1_zero, rsp0_valid);
    end
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    drive0(1'b1, 32'd3, 32'd4, 4'd1, 32'h0);
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++; $display("FAIL rmid_accept: got %b required 1", req0_ready);
    end
    step();
    drive0(1'b0, 32'd3, 32'd4, 4'd1, 32'h0);
    #2;
    reset_n = 1'b0;
    exp_q0.delete();
    req0_valid = 1'b1;
    drive1(1'b1, 32'd9, 32'd9, 4'd2, 32'h0);
    #1;
    vectors++;
    if (alu_a !== '0 || alu_b !== '0 || alu_op !== '0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
        req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      miscompares++; $display("FAIL rmid_clear: a=%h b=%h op=%h v=%b%b rdy=%b%b required all 0",
                              alu_a, alu_b, alu_op, rsp0_valid, rsp1_valid, req0_ready, req1_ready);
    end
    step();
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0) begin
      miscompares++; $display("FAIL rmid_first: rdy=%b%b rsp0_valid=%b required 10 0", req0_ready, req1_ready, rsp0_valid);
    end
    step();
    drive0(1'b0, '0, '0, '0, '0);
    drive1(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    vectors++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      miscompares++; $display("FAIL rmid_norsp: valid=%b%b required 00", rsp0_valid, rsp1_valid);
    end
    repeat (4) step();
  endtask

  task automatic test_drained();
    @(negedge clk);
    vectors++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      miscompares++; $display("FAIL sb_empty: %0d/%0d results never returned", exp_q0.size(), exp_q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_overlap();
    test_reset_mid();
    test_drained();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
